// File: rtl/deint_sched.sv
// deint_sched: receive-side symbol scheduler around the deinterleaver.
// Packs Ncbps serial coded bits into a 289-bit word, launches the
// deinterleaver, waits out its latency, captures the result and streams it
// out serially, once per OFDM symbol, for num_sym symbols per packet.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in FILL, out_valid only in DRAIN, and
// both depend only on the state register, so neither combinationally
// depends on the partner's valid/ready.
module deint_sched #(
  parameter int DEINT_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   rate,
  input  logic [11:0]  num_sym,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [288:0] di_m,
  output logic [7:0]   di_ncbps,
  input  logic [288:0] di_out,
  output logic         out_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         err_rate,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     ncbps_q, ncbps_d;
  logic [11:0]    nsym_q, nsym_d;
  logic [288:0]   di_m_q, di_m_d;
  logic [8:0]     bcnt_q, bcnt_d;
  logic [11:0]    scnt_q, scnt_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [287:0]   obuf_q, obuf_d;
  logic [8:0]     ocnt_q, ocnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [8:0]     rate_ncbps;

  // RATE code to coded bits per symbol; zero marks an illegal code.
  function automatic logic [8:0] rate_to_ncbps(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111: rate_to_ncbps = 9'd48;
      4'b0101, 4'b0111: rate_to_ncbps = 9'd96;
      4'b1001, 4'b1011: rate_to_ncbps = 9'd192;
      4'b0001, 4'b0011: rate_to_ncbps = 9'd288;
      default:          rate_to_ncbps = 9'd0;
    endcase
  endfunction

  assign rate_ncbps = rate_to_ncbps(rate);

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d = state_q;
    ncbps_d = ncbps_q;
    nsym_d  = nsym_q;
    di_m_d  = di_m_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    wcnt_d  = wcnt_q;
    obuf_d  = obuf_q;
    ocnt_d  = ocnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (rate_ncbps == 9'd0) begin
            err_d = 1'b1;
          end else if (num_sym == 12'd0) begin
            done_d = 1'b1;
          end else begin
            ncbps_d = rate_ncbps;
            nsym_d  = num_sym;
            di_m_d  = '0;
            bcnt_d  = '0;
            scnt_d  = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (in_valid) begin
          di_m_d[bcnt_q] = in_bit;
          bcnt_d         = bcnt_q + 9'd1;
          if (bcnt_q == ncbps_q - 9'd1) begin
            wcnt_d  = 4'(DEINT_LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          // Only the Ncbps meaningful bits are kept; the rest read as 0.
          for (int i = 0; i < 288; i++) begin
            obuf_d[i] = (9'(i) < ncbps_q) ? di_out[i] : 1'b0;
          end
          ocnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          ocnt_d = ocnt_q + 9'd1;
          if (ocnt_q == ncbps_q - 9'd1) begin
            if (scnt_q == nsym_q - 12'd1) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              scnt_d  = scnt_q + 12'd1;
              di_m_d  = '0;
              bcnt_d  = '0;
              state_d = S_FILL;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ncbps_q <= '0;
      nsym_q  <= '0;
      di_m_q  <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      wcnt_q  <= '0;
      obuf_q  <= '0;
      ocnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ncbps_q <= ncbps_d;
      nsym_q  <= nsym_d;
      di_m_q  <= di_m_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
      obuf_q  <= obuf_d;
      ocnt_q  <= ocnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_DRAIN);
  assign out_bit   = (state_q == S_DRAIN) && obuf_q[ocnt_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err_rate  = err_q;
  assign di_m      = di_m_q;
  // The port is 8 bits wide, so 288 appears as 8'h20; the rate set is
  // fixed, so the deinterleaver can still tell it apart from the others.
  assign di_ncbps  = ncbps_q[7:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_deint_sched.sv
// Directed testbench for deint_sched with a one-register deinterleaver
// stub that is either an identity or a behavioural 802.11a deinterleaver.
module tb_deint_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   rate;
  logic [11:0]  num_sym;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [288:0] di_m;
  logic [7:0]   di_ncbps;
  logic [288:0] di_out;
  logic         out_bit;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err_rate;
  logic [1:0]   dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic use_real = 1'b0;
  int   model_n  = 48;
  logic exp_q[$];

  always #5 clk = ~clk;

  deint_sched #(.DEINT_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .rate(rate), .num_sym(num_sym),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .di_m(di_m), .di_ncbps(di_ncbps), .di_out(di_out),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err_rate(err_rate), .dbg_state(dbg_state)
  );

  // Reference 802.11a deinterleaver: input index j lands at output index k.
  function automatic logic [288:0] deint_model(input logic [288:0] m, input int n);
    logic [288:0] r;
    int s, i, k;
    r = '0;
    s = (n == 192) ? 2 : ((n == 288) ? 3 : 1);
    for (int j = 0; j < n; j++) begin
      i = s * (j / s) + ((j + (16 * j) / n) % s);
      k = 16 * i - (n - 1) * ((16 * i) / n);
      r[k] = m[j];
    end
    return r;
  endfunction

  // One-cycle deinterleaver stub.
  always @(posedge clk) di_out <= use_real ? deint_model(di_m, model_n) : di_m;

  task automatic check(input string tag, input logic [288:0] obs, input logic [288:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // FILL and DRAIN must never overlap.
  always @(negedge clk) if (reset === 1'b1) check("no_overlap", {288'b0, in_ready & out_valid}, '0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [3:0] r, input logic [11:0] n);
    start = 1'b1; rate = r; num_sym = n;
    tick();
    start = 1'b0; rate = 4'b0000; num_sym = 12'd0;
  endtask

  task automatic send_sym(input int n, input logic [288:0] v, input logic [288:0] gaps);
    int c;
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        tick();
      end
      c = 0;
      while (!in_ready && c < 64) begin tick(); c++; end
      if (!in_ready) check("in_ready_timeout", {288'b0, in_ready}, 289'd1);
      in_valid = 1'b1; in_bit = v[i];
      tick();
    end
    in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic recv_sym(input int n, output logic [288:0] v);
    int c;
    v = '0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = 0;
      while (!out_valid && c < 64) begin tick(); c++; end
      if (!out_valid) check("out_valid_timeout", {288'b0, out_valid}, 289'd1);
      v[i] = out_bit;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {288'b0, in_ready}, '0);
    check({tag, "_out_valid"}, {288'b0, out_valid}, '0);
    check({tag, "_out_bit"}, {288'b0, out_bit}, '0);
    check({tag, "_busy"}, {288'b0, busy}, '0);
    check({tag, "_done"}, {288'b0, done}, '0);
    check({tag, "_err_rate"}, {288'b0, err_rate}, '0);
    check({tag, "_di_m"}, di_m, '0);
    check({tag, "_di_ncbps"}, {281'b0, di_ncbps}, '0);
    check({tag, "_state"}, {287'b0, dbg_state}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [288:0] vec, got, gaps, expv;
    int idx, cyc;
    logic tog;

    // Power-on reset.
    reset = 1'b0; start = 1'b0; rate = 4'b0000; num_sym = 12'd0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_idle_outputs("por");
    reset = 1'b1;
    tick();

    // Illegal rate: one err_rate pulse, never busy.
    start_pkt(4'b0000, 12'd1);
    check("err_pulse", {288'b0, err_rate}, 289'd1);
    check("err_busy", {288'b0, busy}, '0);
    check("err_in_ready", {288'b0, in_ready}, '0);
    tick();
    check("err_one_cycle", {288'b0, err_rate}, '0);
    check("err_busy2", {288'b0, busy}, '0);

    // num_sym = 0: done the cycle after start, stays idle.
    start_pkt(4'b1101, 12'd0);
    check("zero_done", {288'b0, done}, 289'd1);
    check("zero_busy", {288'b0, busy}, '0);
    tick();
    check("zero_done_clear", {288'b0, done}, '0);

    // Identity path, two 48-bit symbols.
    start_pkt(4'b1101, 12'd2);
    check("id_busy", {288'b0, busy}, 289'd1);
    check("id_in_ready", {288'b0, in_ready}, 289'd1);
    check("id_ncbps", {281'b0, di_ncbps}, 289'd48);
    vec = '0;
    for (int i = 0; i < 48; i++) vec[i] = (i % 3 == 0);
    send_sym(48, vec, '0);
    check("id_wait_state", {287'b0, dbg_state}, 289'd2);
    check("id_ov_e0", {288'b0, out_valid}, '0);
    tick();
    check("id_ov_e1", {288'b0, out_valid}, '0);
    tick();
    check("id_ov_e2", {288'b0, out_valid}, 289'd1);
    recv_sym(48, got);
    check("id_sym0_bits", got, vec);
    check("id_boundary_fill", {288'b0, in_ready}, 289'd1);
    check("id_boundary_done", {288'b0, done}, '0);
    vec = '0;
    for (int i = 0; i < 48; i++) vec[i] = (i % 5 == 0);
    send_sym(48, vec, '0);
    recv_sym(48, got);
    check("id_sym1_bits", got, vec);
    check("id_done", {288'b0, done}, 289'd1);
    check("id_idle", {288'b0, busy}, '0);
    tick();
    check("id_done_once", {288'b0, done}, '0);

    // Real deinterleaver: input position 1 maps to output position 16.
    use_real = 1'b1; model_n = 48;
    start_pkt(4'b1101, 12'd1);
    vec = '0; vec[1] = 1'b1;
    send_sym(48, vec, '0);
    recv_sym(48, got);
    expv = '0; expv[16] = 1'b1;
    check("real_pos16", got, expv);
    use_real = 1'b0;
    tick();

    // Back-pressure at 288 bits: in_valid gaps and out_ready toggling.
    start_pkt(4'b0001, 12'd1);
    vec = '0; gaps = '0;
    for (int i = 0; i < 288; i++) begin
      vec[i] = 1'($urandom_range(0, 1));
      exp_q.push_back(vec[i]);
    end
    for (int g = 0; g < 5; g++) gaps[g * 57 + $urandom_range(0, 50)] = 1'b1;
    send_sym(288, vec, gaps);
    check("bp_di_m", di_m, vec);
    check("bp_di_m_288", {288'b0, di_m[288]}, '0);
    idx = 0; cyc = 0; tog = 1'b1;
    while (idx < 288 && cyc < 2000) begin
      out_ready = tog;
      tog = ~tog;
      if (out_valid && out_ready) begin
        check("bp_bit", {288'b0, out_bit}, {288'b0, exp_q.pop_front()});
        idx++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("bp_count", 289'(idx), 289'd288);
    check("bp_queue_empty", 289'(exp_q.size()), '0);
    check("bp_done", {288'b0, done}, 289'd1);
    tick();

    // A start during WAIT is ignored.
    start_pkt(4'b1101, 12'd1);
    vec = '0;
    for (int i = 0; i < 48; i++) vec[i] = (i % 2 == 1);
    send_sym(48, vec, '0);
    start = 1'b1; rate = 4'b0000; num_sym = 12'd0;
    tick();
    start = 1'b0;
    check("wait_start_err", {288'b0, err_rate}, '0);
    check("wait_start_done", {288'b0, done}, '0);
    check("wait_start_busy", {288'b0, busy}, 289'd1);
    check("wait_start_ncbps", {281'b0, di_ncbps}, 289'd48);
    recv_sym(48, got);
    check("wait_start_bits", got, vec);
    check("wait_start_fin", {288'b0, done}, 289'd1);

    // Back-to-back packets: 192 then 96.
    start_pkt(4'b1001, 12'd1);
    check("b2b_ncbps192", {281'b0, di_ncbps}, 289'd192);
    vec = '0;
    for (int i = 0; i < 192; i++) vec[i] = 1'($urandom_range(0, 1));
    send_sym(192, vec, '0);
    recv_sym(192, got);
    check("b2b_bits192", got, vec);
    check("b2b_done192", {288'b0, done}, 289'd1);
    start_pkt(4'b0101, 12'd1);
    check("b2b_ncbps96", {281'b0, di_ncbps}, 289'd96);
    vec = '0;
    for (int i = 0; i < 96; i++) vec[i] = 1'($urandom_range(0, 1));
    send_sym(96, vec, '0);
    recv_sym(96, got);
    check("b2b_bits96", got, vec);
    check("b2b_done96", {288'b0, done}, 289'd1);
    tick();

    // Reset held for 3 cycles in the middle of DRAIN.
    start_pkt(4'b1101, 12'd2);
    vec = '0;
    for (int i = 0; i < 48; i++) vec[i] = 1'b1;
    send_sym(48, vec, '0);
    recv_sym(10, got);
    check("pre_reset_drain", {287'b0, dbg_state}, 289'd3);
    reset = 1'b0;
    tick();
    check_idle_outputs("rst_first");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
